// File: rtl/acc_stack.sv
// Accumulator with ALU ops, status flags and a LIFO save/restore stack.
// All state changes on the falling clock edge; reset is async active-low.
module acc_stack #(
    parameter int DataWidth  = 32,
    parameter int StackDepth = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ACCOpEn,
    input  logic [2:0]           ACCOp,
    input  logic [DataWidth-1:0] ACCDataIn,
    input  logic                 ACCPush,
    input  logic                 ACCPop,
    input  logic                 ACCErrClr,
    output logic [DataWidth-1:0] ACCDataOut,
    output logic                 ACCNeg,
    output logic                 ACCZero,
    output logic                 ACCCarry,
    output logic                 ACCOverflow,
    output logic                 ACCStackFull,
    output logic                 ACCStackEmpty,
    output logic                 ACCStackErr
);

    localparam int CntW = $clog2(StackDepth + 1);
    localparam int IdxW = (StackDepth > 1) ? $clog2(StackDepth) : 1;
    localparam int Msb  = DataWidth - 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(StackDepth);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_SAR  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    logic [DataWidth-1:0] acc;
    logic                 carry;
    logic                 ovf;
    logic [CntW-1:0]      cnt;
    logic                 err;
    logic [DataWidth-1:0] mem [StackDepth];

    logic [DataWidth-1:0] acc_n;
    logic                 carry_n;
    logic                 ovf_n;
    logic [CntW-1:0]      cnt_n;
    logic                 err_n;

    logic [DataWidth-1:0] alu_acc;
    logic                 alu_c;
    logic                 alu_v;
    logic [DataWidth:0]   sum;
    logic [DataWidth:0]   diff;

    logic            full;
    logic            empty;
    logic            push_req;
    logic            pop_req;
    logic            push_ok;
    logic            pop_ok;
    logic            err_evt;
    logic [CntW-1:0] top_cnt;
    logic [IdxW-1:0] wr_idx;
    logic [IdxW-1:0] rd_idx;
    op_e             op;

    assign op = op_e'(ACCOp);

    assign empty = (cnt == '0);
    assign full  = (cnt == FullCnt);

    // Simultaneous push and pop is an error and touches neither.
    assign push_req = ACCPush & ~ACCPop;
    assign pop_req  = ACCPop & ~ACCPush;
    assign push_ok  = push_req & ~full;
    assign pop_ok   = pop_req & ~empty;
    assign err_evt  = (ACCPush & ACCPop)
                    | (push_req & full)
                    | (pop_req & empty);

    assign top_cnt = cnt - CntW'(1);
    assign wr_idx  = cnt[IdxW-1:0];
    assign rd_idx  = top_cnt[IdxW-1:0];

    assign sum  = {1'b0, acc} + {1'b0, ACCDataIn};
    assign diff = {1'b0, acc} - {1'b0, ACCDataIn};

    always_comb begin
        alu_acc = acc;
        alu_c   = carry;
        alu_v   = ovf;
        if (ACCOpEn) begin
            unique case (op)
                OP_NOP: ;
                OP_LOAD: begin
                    alu_acc = ACCDataIn;
                    alu_c   = 1'b0;
                    alu_v   = 1'b0;
                end
                OP_ADD: begin
                    alu_acc = sum[Msb:0];
                    alu_c   = sum[DataWidth];
                    alu_v   = (acc[Msb] == ACCDataIn[Msb])
                            && (sum[Msb] != acc[Msb]);
                end
                OP_SUB: begin
                    // MSB of the widened difference is the borrow.
                    alu_acc = diff[Msb:0];
                    alu_c   = diff[DataWidth];
                    alu_v   = (acc[Msb] != ACCDataIn[Msb])
                            && (diff[Msb] != acc[Msb]);
                end
                OP_SHL: begin
                    alu_acc = {acc[Msb-1:0], 1'b0};
                    alu_c   = acc[Msb];
                    alu_v   = 1'b0;
                end
                OP_SHR: begin
                    alu_acc = {1'b0, acc[Msb:1]};
                    alu_c   = acc[0];
                    alu_v   = 1'b0;
                end
                OP_SAR: begin
                    alu_acc = {acc[Msb], acc[Msb:1]};
                    alu_c   = acc[0];
                    alu_v   = 1'b0;
                end
                OP_CLR: begin
                    alu_acc = '0;
                    alu_c   = 1'b0;
                    alu_v   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        acc_n   = alu_acc;
        carry_n = alu_c;
        ovf_n   = alu_v;
        cnt_n   = cnt;
        // A successful pop discards any op issued with it.
        if (pop_ok) begin
            acc_n   = mem[rd_idx];
            carry_n = 1'b0;
            ovf_n   = 1'b0;
            cnt_n   = top_cnt;
        end else if (push_ok) begin
            cnt_n = cnt + CntW'(1);
        end
        err_n = err_evt | (err & ~ACCErrClr);
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            acc   <= acc_n;
            carry <= carry_n;
            ovf   <= ovf_n;
            cnt   <= cnt_n;
            err   <= err_n;
        end
    end

    // Entry storage is not reset; count gates all reads.
    always_ff @(negedge clock) begin
        if (reset && push_ok) begin
            mem[wr_idx] <= acc;
        end
    end

    assign ACCDataOut    = acc;
    assign ACCNeg        = acc[Msb];
    assign ACCZero       = ~|acc;
    assign ACCCarry      = carry;
    assign ACCOverflow   = ovf;
    assign ACCStackFull  = full;
    assign ACCStackEmpty = empty;
    assign ACCStackErr   = err;

endmodule

// File: tb/tb_acc_stack.sv
// Self-checking bench for acc_stack: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_acc_stack;

    localparam int W = 32;
    localparam int D = 4;

    logic         clock = 1'b1;
    logic         reset = 1'b0;
    logic         ACCOpEn = 1'b0;
    logic [2:0]   ACCOp = 3'd0;
    logic [W-1:0] ACCDataIn = '0;
    logic         ACCPush = 1'b0;
    logic         ACCPop = 1'b0;
    logic         ACCErrClr = 1'b0;
    logic [W-1:0] ACCDataOut;
    logic         ACCNeg;
    logic         ACCZero;
    logic         ACCCarry;
    logic         ACCOverflow;
    logic         ACCStackFull;
    logic         ACCStackEmpty;
    logic         ACCStackErr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] m_acc;
    logic         m_c;
    logic         m_v;
    logic         m_err;
    logic [W-1:0] m_q[$];

    acc_stack #(.DataWidth(W), .StackDepth(D)) dut (
        .clock        (clock),
        .reset        (reset),
        .ACCOpEn      (ACCOpEn),
        .ACCOp        (ACCOp),
        .ACCDataIn    (ACCDataIn),
        .ACCPush      (ACCPush),
        .ACCPop       (ACCPop),
        .ACCErrClr    (ACCErrClr),
        .ACCDataOut   (ACCDataOut),
        .ACCNeg       (ACCNeg),
        .ACCZero      (ACCZero),
        .ACCCarry     (ACCCarry),
        .ACCOverflow  (ACCOverflow),
        .ACCStackFull (ACCStackFull),
        .ACCStackEmpty(ACCStackEmpty),
        .ACCStackErr  (ACCStackErr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".acc"}, 64'(ACCDataOut), 64'(m_acc));
        check({tag, ".neg"}, 64'(ACCNeg), 64'(m_acc[W-1]));
        check({tag, ".zero"}, 64'(ACCZero), 64'(m_acc == '0));
        check({tag, ".carry"}, 64'(ACCCarry), 64'(m_c));
        check({tag, ".ovf"}, 64'(ACCOverflow), 64'(m_v));
        check({tag, ".full"}, 64'(ACCStackFull), 64'(m_q.size() == D));
        check({tag, ".empty"}, 64'(ACCStackEmpty), 64'(m_q.size() == 0));
        check({tag, ".err"}, 64'(ACCStackErr), 64'(m_err));
    endtask

    task automatic model_reset();
        m_acc = '0;
        m_c   = 1'b0;
        m_v   = 1'b0;
        m_err = 1'b0;
        m_q.delete();
    endtask

    task automatic model_op(input logic [2:0] op, input logic [W-1:0] b);
        longint          sa;
        longint          sb;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint          lim;
        sa  = longint'($signed(m_acc));
        sb  = longint'($signed(b));
        ua  = 64'(m_acc);
        ub  = 64'(b);
        lim = 64'sd2147483648;
        case (op)
            3'd1: begin m_acc = b; m_c = 0; m_v = 0; end
            3'd2: begin
                r     = sa + sb;
                m_c   = (ua + ub) > 64'hFFFF_FFFF;
                m_v   = (r >= lim) || (r < -lim);
                m_acc = W'(ua + ub);
            end
            3'd3: begin
                r     = sa - sb;
                m_c   = ua < ub;
                m_v   = (r >= lim) || (r < -lim);
                m_acc = W'(ua - ub);
            end
            3'd4: begin m_c = m_acc[W-1]; m_v = 0; m_acc = m_acc << 1; end
            3'd5: begin m_c = m_acc[0]; m_v = 0; m_acc = m_acc >> 1; end
            3'd6: begin
                m_c   = m_acc[0];
                m_v   = 0;
                m_acc = $signed(m_acc) >>> 1;
            end
            3'd7: begin m_acc = '0; m_c = 0; m_v = 0; end
            default: ;
        endcase
    endtask

    task automatic model_step(input logic en, input logic [2:0] op,
                              input logic [W-1:0] b, input logic push,
                              input logic pop, input logic clr);
        logic [W-1:0] old;
        logic         evt;
        int           n;
        old = m_acc;
        n   = m_q.size();
        evt = (push && pop) || (pop && !push && n == 0)
           || (push && !pop && n == D);
        if (pop && !push && n > 0) begin
            m_acc = m_q.pop_back();
            m_c   = 1'b0;
            m_v   = 1'b0;
        end else begin
            if (en) model_op(op, b);
            if (push && !pop && n < D) m_q.push_back(old);
        end
        m_err = evt || (m_err && !clr);
    endtask

    task automatic step(input string tag, input logic en,
                        input logic [2:0] op, input logic [W-1:0] b,
                        input logic push, input logic pop, input logic clr);
        ACCOpEn   = en;
        ACCOp     = op;
        ACCDataIn = b;
        ACCPush   = push;
        ACCPop    = pop;
        ACCErrClr = clr;
        model_step(en, op, b, push, pop, clr);
        @(negedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("rst");
        #2;
        reset = 1'b1;
        @(negedge clock);
        #1;

        step("r030a", 1, 3'd1, 32'h7FFF_FFFF, 0, 0, 0);
        step("r030b", 1, 3'd2, 32'h1, 0, 0, 0);
        check("r030.acc", 64'(ACCDataOut), 64'h8000_0000);
        check("r030.ovf", 64'(ACCOverflow), 64'h1);

        step("r031a", 1, 3'd1, 32'h0, 0, 0, 0);
        step("r031b", 1, 3'd3, 32'h1, 0, 0, 0);
        check("r031.acc", 64'(ACCDataOut), 64'hFFFF_FFFF);
        step("r031c", 1, 3'd2, 32'h1, 0, 0, 0);
        check("r031.zc", 64'({ACCZero, ACCCarry}), 64'h3);

        step("r032a", 1, 3'd1, 32'h8000_0001, 0, 0, 0);
        step("r032b", 1, 3'd6, 32'h0, 0, 0, 0);
        check("r032.sar", 64'(ACCDataOut), 64'hC000_0000);
        step("r032c", 1, 3'd5, 32'h0, 0, 0, 0);
        check("r032.shr", 64'(ACCDataOut), 64'h6000_0000);
        step("r032d", 1, 3'd4, 32'h0, 0, 0, 0);
        check("r032.shl", 64'(ACCDataOut), 64'hC000_0000);

        for (int i = 1; i <= 4; i++) begin
            step("r033ld", 1, 3'd1, W'(i), 0, 0, 0);
            step("r033pu", 0, 3'd0, '0, 1, 0, 0);
        end
        check("r033.full", 64'(ACCStackFull), 64'h1);
        step("r033ovf", 0, 3'd0, '0, 1, 0, 0);
        check("r033.err", 64'(ACCStackErr), 64'h1);
        for (int i = 4; i >= 1; i--) begin
            step("r033po", 1, 3'd7, '0, 0, 1, 0);
            check("r033.val", 64'(ACCDataOut), 64'(i));
        end
        check("r033.empty", 64'(ACCStackEmpty), 64'h1);

        step("r034a", 1, 3'd0, '0, 0, 0, 1);
        step("r034b", 1, 3'd1, 32'h5, 0, 1, 0);
        check("r034.acc", 64'(ACCDataOut), 64'h5);
        step("r034c", 0, 3'd0, '0, 0, 0, 1);
        check("r034.clr", 64'(ACCStackErr), 64'h0);
        step("r034d", 1, 3'd2, 32'h3, 1, 1, 0);
        step("r034e", 0, 3'd0, '0, 0, 0, 1);
        step("r034f", 0, 3'd0, '0, 1, 1, 1);

        step("r035a", 1, 3'd1, 32'h1234, 0, 0, 0);
        step("r035b", 0, 3'd0, '0, 1, 0, 0);
        do_reset("r035");
        check("r035.zero", 64'(ACCZero), 64'h1);

        for (int i = 0; i < 600; i++) begin
            logic       en;
            logic [2:0] op;
            logic [W-1:0] b;
            logic       pu;
            logic       po;
            logic       cl;
            en = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = W'($urandom_range(0, 3));
                2: b = 32'h7FFF_FFFF ^ W'($urandom_range(0, 1));
                default: b = 32'hFFFF_FFFF ^ W'($urandom_range(0, 1));
            endcase
            pu = ($urandom_range(0, 3) == 0);
            po = ($urandom_range(0, 3) == 0);
            cl = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
            step("rnd", en, op, b, pu, po, cl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/acc_stack.md
ACC_STACK -- requirements
Module: acc_stack

Interface
REQ-001 SHALL have parameter DataWidth, default 32, accumulator and data path width (minimum 2).
REQ-002 SHALL have parameter StackDepth, default 4, number of save/restore stack entries (minimum 1).
REQ-003 SHALL have port clock, input, 1, the single clock; all registers update on the falling edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-005 SHALL have port ACCOpEn, input, 1, execute ACCOp this edge.
REQ-006 SHALL have port ACCOp, input, 3, operation code: 000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 SHL, 101 SHR (logical), 110 SAR (arithmetic), 111 CLR.
REQ-007 SHALL have port ACCDataIn, input, DataWidth, operand B for LOAD/ADD/SUB.
REQ-008 SHALL have port ACCPush, input, 1, save the current accumulator onto the stack.
REQ-009 SHALL have port ACCPop, input, 1, restore the top stack entry into the accumulator.
REQ-010 SHALL have port ACCErrClr, input, 1, clear the sticky error flag.
REQ-011 SHALL have port ACCDataOut, output, DataWidth, accumulator value.
REQ-012 SHALL have ports ACCNeg, ACCZero, ACCCarry and ACCOverflow, each output, 1, status flags.
REQ-013 SHALL have ports ACCStackFull, ACCStackEmpty and ACCStackErr, each output, 1, stack status.

Function
REQ-014 ACCNeg SHALL equal ACCDataOut[DataWidth-1], combinationally.
REQ-015 ACCZero SHALL be 1 exactly when ACCDataOut is all zeros, combinationally for any DataWidth.
REQ-016 With ACCOpEn=1, ACC SHALL update one edge later as follows:
- LOAD: A=B.
- ADD: A=A+B, truncated to DataWidth.
- SUB: A=A-B.
- SHL/SHR/SAR: shift by 1 bit.
- CLR: A=0.
- NOP: hold.
REQ-017 ACCCarry and ACCOverflow SHALL be registered and update only on an executed non-NOP op:
- ADD: Carry=unsigned carry-out; Overflow=two's-complement overflow.
- SUB: Carry=borrow (1 when A<B unsigned); Overflow=signed overflow.
- SHL: Carry=old A[MSB]; Overflow=0.
- SHR/SAR: Carry=old A[0]; Overflow=0.
- LOAD/CLR: both cleared.
REQ-018 With ACCOpEn=0 and no pop, ACC and Carry/Overflow SHALL hold.
REQ-019 The stack SHALL be LIFO, StackDepth entries of DataWidth, with an occupancy count from 0 to StackDepth.
REQ-020 A push SHALL store the pre-edge ACC value and increment the count; an op in the same cycle SHALL still execute on ACC.
REQ-021 A pop SHALL load the top entry into ACC, decrement the count, clear Carry/Overflow, and take priority over any op in the same cycle (the op is discarded).
REQ-022 ACCStackEmpty SHALL equal (count==0); ACCStackFull SHALL equal (count==StackDepth); both are combinational from the count.
REQ-023 The following SHALL leave stack contents and count unchanged and set ACCStackErr on that edge:
- push when full;
- pop when empty;
- push and pop asserted together.
REQ-024 In the REQ-023 error cases, a requested op SHALL still execute normally, except that an op with push+pop together also executes.
REQ-025 ACCStackErr SHALL be sticky until ACCErrClr=1; if an error and ACCErrClr coincide, the error SHALL win (flag stays 1).
REQ-026 ACCOp and ACCDataIn SHALL be ignored when ACCOpEn=0.

Reset
REQ-027 While reset=0, asynchronously:
- ACCDataOut=0, ACCCarry=0, ACCOverflow=0, stack count=0, ACCStackErr=0.
- Resulting outputs: ACCZero=1, ACCNeg=0, ACCStackEmpty=1, ACCStackFull=0.
REQ-028 Stack entry storage need not be reset; it SHALL never be observable while count=0.
REQ-029 Reset asserted mid-sequence SHALL discard any in-flight op or stack request; the first edge after reset release behaves normally.

Verification
REQ-030 (DataWidth=32) LOAD 0x7FFFFFFF, then ADD 1 -> ACC=0x80000000, Neg=1, Overflow=1, Carry=0, Zero=0.
REQ-031 LOAD 0, then SUB 1 -> ACC=0xFFFFFFFF, Carry=1, Overflow=0; then ADD 1 -> ACC=0, Zero=1, Carry=1.
REQ-032 LOAD 0x80000001, then SAR -> 0xC0000000, Carry=1; then SHR -> 0x60000000, Carry=0; then SHL -> 0xC0000000, Carry=0.
REQ-033 (StackDepth=4) Push values 1, 2, 3, 4 -> Full=1; fifth push -> Err=1, count stays 4; four pops -> ACC=4, 3, 2, 1 in turn; Empty=1.
REQ-034 Pop when empty with ACCOpEn=1, LOAD 5 -> ACC=5, Err=1; then ACCErrClr -> Err=0; push+pop together -> count unchanged, Err=1.
REQ-035 Load 0x1234 and push, then assert reset=0 between edges -> outputs reach the REQ-027 values immediately, without a clock edge.
